hazard_control_unit: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RV32I core; the stall-side complement to operand forwarding. It consumes the same stage register indices and write-enables, plus cache handshakes and EX-stage redirects, and produces per-stage load/flush enables. It inserts load-use bubbles and freezes the pipeline on instruction-cache or data-cache misses. A 2-state FSM sequences redirects that arrive while an instruction fetch is still outstanding. Perf counters record stall and flush events.

---
 rtl/rv32i_types.sv | 22 ++
 rtl/hazard_control_unit_if.sv | 36 +++
 rtl/hazard_control_unit_perf_counters.sv | 28 ++
 rtl/hazard_control_unit.sv | 118 +++++++++++
 tb/tb_hazard_control_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I core types: register index, hazard FSM state, perf counter slots.
package rv32i_types;

  typedef logic [4:0] rv32i_reg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } hazard_state_t;

  localparam int NUM_CNT   = 4;
  localparam int CNT_IMEM  = 0;
  localparam int CNT_DMEM  = 1;
  localparam int CNT_LU    = 2;
  localparam int CNT_FLUSH = 3;

  // A source only matters when the instruction actually reads it.
  function automatic logic src_hit(rv32i_reg rd, rv32i_reg rs, logic use_rs);
    return use_rs & (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Datapath <-> hazard unit signal bundle; master is the datapath, slave the hazard unit.
interface hazard_control_unit_if #(
  parameter int CNT_W = 32
);
  import rv32i_types::*;

  rv32i_reg         IFID_rs1, IFID_rs2;
  logic             IFID_use_rs1, IFID_use_rs2;
  rv32i_reg         IDEX_rd;
  logic             IDEX_mem_read;
  logic             ex_redirect;
  logic             imem_read, imem_resp;
  logic             dmem_req, dmem_resp;

  logic             load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic             flush_ifid, flush_idex;
  logic             redirect_hold, sel_pending_pc;
  logic [CNT_W-1:0] cnt_imem_stall, cnt_dmem_stall, cnt_load_use, cnt_flush;

  modport master (
    output IFID_rs1, IFID_rs2, IFID_use_rs1, IFID_use_rs2, IDEX_rd, IDEX_mem_read,
           ex_redirect, imem_read, imem_resp, dmem_req, dmem_resp,
    input  load_pc, load_ifid, load_idex, load_exmem, load_memwb, flush_ifid, flush_idex,
           redirect_hold, sel_pending_pc,
           cnt_imem_stall, cnt_dmem_stall, cnt_load_use, cnt_flush
  );

  modport slave (
    input  IFID_rs1, IFID_rs2, IFID_use_rs1, IFID_use_rs2, IDEX_rd, IDEX_mem_read,
           ex_redirect, imem_read, imem_resp, dmem_req, dmem_resp,
    output load_pc, load_ifid, load_idex, load_exmem, load_memwb, flush_ifid, flush_idex,
           redirect_hold, sel_pending_pc,
           cnt_imem_stall, cnt_dmem_stall, cnt_load_use, cnt_flush
  );

endinterface

// File: rtl/hazard_control_unit_perf_counters.sv
// Wrapping event counters, one increment per cycle at most, cleared by async reset.
module hazard_perf_counters
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CNT-1:0]               inc_i,
  output logic [NUM_CNT-1:0][CNT_W-1:0]    cnt_o
);

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb cnt_d = cnt_q + CNT_W'(inc_i[gi]);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
      end

      assign cnt_o[gi] = cnt_q;
    end
  endgenerate

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller: load-use bubbles, cache-miss freezes, redirect sequencing
// around outstanding fetches, and perf event counters.
module hazard_control_unit
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input logic                    clk,
  input logic                    rst,
  hazard_control_unit_if.slave   hz
);

  hazard_state_t state_q, state_d;
  logic          resp_seen_q, resp_seen_d;
  logic          dstall, istall, lu;
  logic          ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb;
  logic          fl_ifid, fl_idex, hold, sel_pend;
  logic [NUM_CNT-1:0]            cnt_inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_val;

  assign dstall = hz.dmem_req & ~hz.dmem_resp;
  assign istall = hz.imem_read & ~hz.imem_resp;
  assign lu     = hz.IDEX_mem_read & (hz.IDEX_rd != '0) &
                  (src_hit(hz.IDEX_rd, hz.IFID_rs1, hz.IFID_use_rs1) |
                   src_hit(hz.IDEX_rd, hz.IFID_rs2, hz.IFID_use_rs2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      resp_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_seen_q <= resp_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    resp_seen_d = resp_seen_q;
    ld_pc    = 1'b0;
    ld_ifid  = 1'b0;
    ld_idex  = 1'b0;
    ld_exmem = 1'b0;
    ld_memwb = 1'b0;
    fl_ifid  = 1'b0;
    fl_idex  = 1'b0;
    hold     = 1'b0;
    sel_pend = 1'b0;

    // Outputs are combinational, so they must be gated while reset is asserted.
    if (rst && !dstall) begin
      ld_idex  = 1'b1;
      ld_exmem = 1'b1;
      ld_memwb = 1'b1;
      if (state_q == RUN) begin
        if (hz.ex_redirect) begin
          fl_idex = 1'b1;
          if (!istall) begin
            ld_pc   = 1'b1;
            ld_ifid = 1'b1;
            fl_ifid = 1'b1;
          end else begin
            hold    = 1'b1;
            state_d = DRAIN;
          end
        end else if (lu || istall) begin
          fl_idex = 1'b1;
        end else begin
          ld_pc   = 1'b1;
          ld_ifid = 1'b1;
        end
      end else begin
        fl_idex = 1'b1;
        // A response seen during a freeze is replayed here via resp_seen_q.
        if (hz.imem_resp || resp_seen_q) begin
          ld_pc       = 1'b1;
          ld_ifid     = 1'b1;
          fl_ifid     = 1'b1;
          sel_pend    = 1'b1;
          resp_seen_d = 1'b0;
          state_d     = RUN;
        end
      end
    end else if (rst && state_q == DRAIN && hz.imem_resp) begin
      resp_seen_d = 1'b1;
    end
  end

  always_comb begin
    cnt_inc            = '0;
    cnt_inc[CNT_DMEM]  = dstall;
    cnt_inc[CNT_IMEM]  = istall & ~dstall;
    cnt_inc[CNT_LU]    = lu & ~dstall & ~hz.ex_redirect;
    cnt_inc[CNT_FLUSH] = hz.ex_redirect & (state_q == RUN) & ~dstall;
  end

  hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk   (clk),
    .rst   (rst),
    .inc_i (cnt_inc),
    .cnt_o (cnt_val)
  );

  assign hz.load_pc        = ld_pc;
  assign hz.load_ifid      = ld_ifid;
  assign hz.load_idex      = ld_idex;
  assign hz.load_exmem     = ld_exmem;
  assign hz.load_memwb     = ld_memwb;
  assign hz.flush_ifid     = fl_ifid;
  assign hz.flush_idex     = fl_idex;
  assign hz.redirect_hold  = hold;
  assign hz.sel_pending_pc = sel_pend;
  assign hz.cnt_imem_stall = cnt_val[CNT_IMEM];
  assign hz.cnt_dmem_stall = cnt_val[CNT_DMEM];
  assign hz.cnt_load_use   = cnt_val[CNT_LU];
  assign hz.cnt_flush      = cnt_val[CNT_FLUSH];

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit; outputs are packed as
// {load_pc, load_ifid, load_idex, load_exmem, load_memwb, flush_ifid, flush_idex, redirect_hold, sel_pending_pc}.
module tb_hazard_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;

  localparam logic [8:0] O_IDLE  = 9'b111110000;
  localparam logic [8:0] O_BUBL  = 9'b001110100;
  localparam logic [8:0] O_REDIR = 9'b111111100;
  localparam logic [8:0] O_HOLD  = 9'b001110110;
  localparam logic [8:0] O_EXIT  = 9'b111111101;
  localparam logic [8:0] O_ZERO  = 9'b000000000;

  hazard_control_unit_if #(.CNT_W(32)) hif ();

  hazard_control_unit #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {hif.load_pc, hif.load_ifid, hif.load_idex, hif.load_exmem, hif.load_memwb,
            hif.flush_ifid, hif.flush_idex, hif.redirect_hold, hif.sel_pending_pc};
  endfunction

  task automatic idle();
    hif.IFID_rs1 = 5'd0;  hif.IFID_rs2 = 5'd0;
    hif.IFID_use_rs1 = 1'b0; hif.IFID_use_rs2 = 1'b0;
    hif.IDEX_rd = 5'd0;   hif.IDEX_mem_read = 1'b0;
    hif.ex_redirect = 1'b0;
    hif.imem_read = 1'b0; hif.imem_resp = 1'b0;
    hif.dmem_req = 1'b0;  hif.dmem_resp = 1'b0;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] o;
    idle();
    #2;
    o = outs();
    n_vec++;
    if (o !== O_ZERO) begin n_miss++; $display("FAIL reset_outs got=%b exp=%b", o, O_ZERO); end
    else $display("reset_outs got=%b", o);
    n_vec++;
    if ({hif.cnt_imem_stall, hif.cnt_dmem_stall, hif.cnt_load_use, hif.cnt_flush} !== 128'd0) begin
      n_miss++; $display("FAIL reset_cnts got nonzero exp=0");
    end else $display("reset_cnts zero");
    next();
    rst = 1'b1;
    settle();
    o = outs();
    n_vec++;
    if (o !== O_IDLE) begin n_miss++; $display("FAIL post_reset_idle got=%b exp=%b", o, O_IDLE); end
    else $display("post_reset_idle got=%b", o);
    next();
  endtask

  task automatic test_load_use();
    logic [8:0] o;
    idle(); hif.IDEX_mem_read = 1'b1; hif.IDEX_rd = 5'd5; hif.IFID_rs1 = 5'd5; hif.IFID_use_rs1 = 1'b1;
    settle(); o = outs(); n_vec++;
    if (o !== O_BUBL) begin n_miss++; $display("FAIL lu_rs1_stall got=%b exp=%b", o, O_BUBL); end
    else $display("lu_rs1_stall got=%b", o);
    next(); n_vec++;
    if (hif.cnt_load_use !== 32'd1) begin n_miss++; $display("FAIL lu_cnt1 got=%0d exp=1", hif.cnt_load_use); end
    else $display("lu_cnt1 got=%0d", hif.cnt_load_use);
    idle(); settle(); o = outs(); n_vec++;
    if (o !== O_IDLE) begin n_miss++; $display("FAIL lu_single_bubble got=%b exp=%b", o, O_IDLE); end
    else $display("lu_single_bubble got=%b", o);
    next();
    idle(); hif.IDEX_mem_read = 1'b1; hif.IDEX_rd = 5'd0; hif.IFID_rs1 = 5'd0; hif.IFID_use_rs1 = 1'b1;
    settle(); o = outs(); n_vec++;
    if (o !== O_IDLE) begin n_miss++; $display("FAIL lu_rd0 got=%b exp=%b", o, O_IDLE); end
    else $display("lu_rd0 got=%b", o);
    next();
    idle(); hif.IDEX_mem_read = 1'b1; hif.IDEX_rd = 5'd7; hif.IFID_rs1 = 5'd7; hif.IFID_rs2 = 5'd7; hif.IFID_use_rs2 = 1'b1;
    settle(); o = outs(); n_vec++;
    if (o !== O_BUBL) begin n_miss++; $display("FAIL lu_rs2_stall got=%b exp=%b", o, O_BUBL); end
    else $display("lu_rs2_stall got=%b", o);
    next();
    idle(); hif.IDEX_mem_read = 1'b1; hif.IDEX_rd = 5'd7; hif.IFID_rs1 = 5'd7; hif.IFID_rs2 = 5'd7;
    settle(); o = outs(); n_vec++;
    if (o !== O_IDLE) begin n_miss++; $display("FAIL lu_unused_src got=%b exp=%b", o, O_IDLE); end
    else $display("lu_unused_src got=%b", o);
    next(); n_vec++;
    if (hif.cnt_load_use !== 32'd2) begin n_miss++; $display("FAIL lu_cnt2 got=%0d exp=2", hif.cnt_load_use); end
    else $display("lu_cnt2 got=%0d", hif.cnt_load_use);
  endtask

  task automatic test_dmiss();
    logic [8:0] o;
    for (int i = 0; i < 4; i++) begin
      idle(); hif.dmem_req = 1'b1; hif.dmem_resp = (i == 3);
      hif.ex_redirect = 1'b1;
      hif.IDEX_mem_read = 1'b1; hif.IDEX_rd = 5'd3; hif.IFID_rs1 = 5'd3; hif.IFID_use_rs1 = 1'b1;
      settle(); o = outs(); n_vec++;
      if (o !== ((i == 3) ? O_REDIR : O_ZERO)) begin
        n_miss++; $display("FAIL dmiss_cyc%0d got=%b exp=%b", i, o, (i == 3) ? O_REDIR : O_ZERO);
      end else $display("dmiss_cyc%0d got=%b", i, o);
      next();
    end
    n_vec++;
    if (hif.cnt_dmem_stall !== 32'd3) begin n_miss++; $display("FAIL dmiss_cnt got=%0d exp=3", hif.cnt_dmem_stall); end
    else $display("dmiss_cnt got=%0d", hif.cnt_dmem_stall);
    n_vec++;
    if (hif.cnt_flush !== 32'd1 || hif.cnt_load_use !== 32'd2) begin
      n_miss++; $display("FAIL dmiss_side_cnts got flush=%0d lu=%0d exp flush=1 lu=2", hif.cnt_flush, hif.cnt_load_use);
    end else $display("dmiss_side_cnts flush=%0d lu=%0d", hif.cnt_flush, hif.cnt_load_use);
  endtask

  task automatic test_redirect_nofetch();
    logic [8:0] o;
    idle(); hif.ex_redirect = 1'b1;
    settle(); o = outs(); n_vec++;
    if (o !== O_REDIR) begin n_miss++; $display("FAIL redir_nofetch got=%b exp=%b", o, O_REDIR); end
    else $display("redir_nofetch got=%b", o);
    next(); n_vec++;
    if (hif.cnt_flush !== 32'd2) begin n_miss++; $display("FAIL redir_cnt got=%0d exp=2", hif.cnt_flush); end
    else $display("redir_cnt got=%0d", hif.cnt_flush);
  endtask

  task automatic test_redirect_imiss();
    logic [8:0] o;
    idle(); hif.imem_read = 1'b1; hif.ex_redirect = 1'b1;
    settle(); o = outs(); n_vec++;
    if (o !== O_HOLD) begin n_miss++; $display("FAIL imiss_hold got=%b exp=%b", o, O_HOLD); end
    else $display("imiss_hold got=%b", o);
    next();
    for (int i = 1; i <= 5; i++) begin
      idle(); hif.imem_read = 1'b1; hif.imem_resp = (i == 5);
      hif.ex_redirect = (i == 2);
      settle(); o = outs(); n_vec++;
      if (o !== ((i == 5) ? O_EXIT : O_BUBL)) begin
        n_miss++; $display("FAIL imiss_drain%0d got=%b exp=%b", i, o, (i == 5) ? O_EXIT : O_BUBL);
      end else $display("imiss_drain%0d got=%b", i, o);
      next();
    end
    idle(); settle(); o = outs(); n_vec++;
    if (o !== O_IDLE) begin n_miss++; $display("FAIL imiss_back_run got=%b exp=%b", o, O_IDLE); end
    else $display("imiss_back_run got=%b", o);
    next(); n_vec++;
    if (hif.cnt_flush !== 32'd3 || hif.cnt_imem_stall !== 32'd5) begin
      n_miss++; $display("FAIL imiss_cnts got flush=%0d imem=%0d exp flush=3 imem=5", hif.cnt_flush, hif.cnt_imem_stall);
    end else $display("imiss_cnts flush=%0d imem=%0d", hif.cnt_flush, hif.cnt_imem_stall);
  endtask

  task automatic test_drain_dstall();
    logic [8:0] o;
    idle(); hif.imem_read = 1'b1; hif.ex_redirect = 1'b1;
    settle(); next();
    idle(); hif.imem_read = 1'b1; hif.imem_resp = 1'b1; hif.dmem_req = 1'b1;
    settle(); o = outs(); n_vec++;
    if (o !== O_ZERO) begin n_miss++; $display("FAIL ds_resp_frozen got=%b exp=%b", o, O_ZERO); end
    else $display("ds_resp_frozen got=%b", o);
    next();
    idle(); hif.dmem_req = 1'b1;
    settle(); o = outs(); n_vec++;
    if (o !== O_ZERO) begin n_miss++; $display("FAIL ds_still_frozen got=%b exp=%b", o, O_ZERO); end
    else $display("ds_still_frozen got=%b", o);
    next();
    idle(); settle(); o = outs(); n_vec++;
    if (o !== O_EXIT) begin n_miss++; $display("FAIL ds_exit got=%b exp=%b", o, O_EXIT); end
    else $display("ds_exit got=%b", o);
    next();
    idle(); settle(); o = outs(); n_vec++;
    if (o !== O_IDLE) begin n_miss++; $display("FAIL ds_exit_once got=%b exp=%b", o, O_IDLE); end
    else $display("ds_exit_once got=%b", o);
    next(); n_vec++;
    if (hif.cnt_dmem_stall !== 32'd5 || hif.cnt_flush !== 32'd4 || hif.cnt_imem_stall !== 32'd6) begin
      n_miss++; $display("FAIL ds_cnts got dmem=%0d flush=%0d imem=%0d exp dmem=5 flush=4 imem=6",
                         hif.cnt_dmem_stall, hif.cnt_flush, hif.cnt_imem_stall);
    end else $display("ds_cnts dmem=%0d flush=%0d imem=%0d", hif.cnt_dmem_stall, hif.cnt_flush, hif.cnt_imem_stall);
  endtask

  task automatic test_async_reset();
    logic [8:0] o;
    idle(); hif.imem_read = 1'b1; hif.ex_redirect = 1'b1;
    settle(); next();
    idle(); hif.imem_read = 1'b1;
    #2; rst = 1'b0; #1;
    o = outs(); n_vec++;
    if (o !== O_ZERO) begin n_miss++; $display("FAIL arst_outs got=%b exp=%b", o, O_ZERO); end
    else $display("arst_outs got=%b", o);
    n_vec++;
    if ({hif.cnt_imem_stall, hif.cnt_dmem_stall, hif.cnt_load_use, hif.cnt_flush} !== 128'd0) begin
      n_miss++; $display("FAIL arst_cnts got imem=%0d dmem=%0d lu=%0d flush=%0d exp=0",
                         hif.cnt_imem_stall, hif.cnt_dmem_stall, hif.cnt_load_use, hif.cnt_flush);
    end else $display("arst_cnts zero");
    next();
    idle(); #2; rst = 1'b1; #1;
    o = outs(); n_vec++;
    if (o !== O_IDLE) begin n_miss++; $display("FAIL arst_run got=%b exp=%b", o, O_IDLE); end
    else $display("arst_run got=%b", o);
    next();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_dmiss();
    test_redirect_nofetch();
    test_redirect_imiss();
    test_drain_dstall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
